// File: rtl/y86_pkg.sv
// Shared Y86 encodings and the default-width Decode->Execute bundle.
package y86_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned REG_W_DEF  = 4;
    localparam int unsigned STAT_W_DEF = 3;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    // Execute-stage payload at the architectural default widths
    typedef struct packed {
        logic [STAT_W_DEF-1:0] stat;
        logic [3:0]            icode;
        logic [3:0]            ifun;
        logic [DATA_W_DEF-1:0] val_c;
        logic [DATA_W_DEF-1:0] val_a;
        logic [DATA_W_DEF-1:0] val_b;
        logic [REG_W_DEF-1:0]  dst_e;
        logic [REG_W_DEF-1:0]  dst_m;
        logic [REG_W_DEF-1:0]  src_a;
        logic [REG_W_DEF-1:0]  src_b;
    } e_bundle_t;

    localparam e_bundle_t E_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        val_c: '0,
        val_a: '0,
        val_b: '0,
        dst_e: RNONE,
        dst_m: RNONE,
        src_a: RNONE,
        src_b: RNONE
    };

endpackage

// File: rtl/e_stage_reg_p_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, never wrapping past the maximum value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/e_stage_reg_p.sv
// Decode->Execute pipeline register with stall, bubble, wrong-path squash and event counters.
module e_stage_reg_p
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned STAT_W     = 3,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RESET_STAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              E_stall,
    input  logic              E_bubble,
    input  logic [STAT_W-1:0] D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] d_valA,
    input  logic [DATA_W-1:0] d_valB,
    input  logic [REG_W-1:0]  d_dstE,
    input  logic [REG_W-1:0]  d_dstM,
    input  logic [REG_W-1:0]  d_srcA,
    input  logic [REG_W-1:0]  d_srcB,
    input  logic [3:0]        M_icode,
    input  logic              e_Cnd,
    output logic [STAT_W-1:0] E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [REG_W-1:0]  E_dstE,
    output logic [REG_W-1:0]  E_dstM,
    output logic [REG_W-1:0]  E_srcA,
    output logic [REG_W-1:0]  E_srcB,
    output logic              E_valid,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  squash_cnt,
    output logic              proto_err
);

    // Payload at this instance's widths
    typedef struct packed {
        logic [STAT_W-1:0] stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] val_c;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [REG_W-1:0]  dst_e;
        logic [REG_W-1:0]  dst_m;
        logic [REG_W-1:0]  src_a;
        logic [REG_W-1:0]  src_b;
    } stage_t;

    localparam stage_t BUBBLE_IMG = '{
        stat:  STAT_W'(RESET_STAT),
        icode: INOP,
        ifun:  4'h0,
        val_c: {DATA_W{1'b0}},
        val_a: {DATA_W{1'b0}},
        val_b: {DATA_W{1'b0}},
        dst_e: {REG_W{1'b1}},
        dst_m: {REG_W{1'b1}},
        src_a: {REG_W{1'b1}},
        src_b: {REG_W{1'b1}}
    };

    stage_t e_q;
    stage_t load_c;
    logic   load_en_c;
    logic   squash_c;
    logic   stall_inc_c;

    // Decode next contents; a not-taken jump in M squashes a faulting wrong-path status
    always_comb begin
        load_en_c   = !E_bubble && !E_stall;
        squash_c    = load_en_c && (M_icode == IJXX) && !e_Cnd && (D_stat != STAT_W'(SAOK));
        stall_inc_c = E_stall && !E_bubble;
        load_c = '{
            stat:  squash_c ? STAT_W'(SAOK) : D_stat,
            icode: D_icode,
            ifun:  D_ifun,
            val_c: D_valC,
            val_a: d_valA,
            val_b: d_valB,
            dst_e: d_dstE,
            dst_m: d_dstM,
            src_a: d_srcA,
            src_b: d_srcB
        };
    end

    // Stage register: bubble beats stall beats load; protocol error is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= BUBBLE_IMG;
            E_valid   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (E_bubble) begin
                e_q     <= BUBBLE_IMG;
                E_valid <= 1'b0;
            end else if (!E_stall) begin
                e_q     <= load_c;
                E_valid <= 1'b1;
            end
            if (E_stall && E_bubble) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.val_c;
    assign E_valA  = e_q.val_a;
    assign E_valB  = e_q.val_b;
    assign E_dstE  = e_q.dst_e;
    assign E_dstM  = e_q.dst_m;
    assign E_srcA  = e_q.src_a;
    assign E_srcB  = e_q.src_b;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (E_bubble),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_c),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_squash_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (squash_c),
        .count (squash_cnt)
    );

endmodule

// File: doc/e_stage_reg_p.md
Name: e_stage_reg_p

Overview:
Parametrised Decode→Execute pipeline register for the Y86 pipeline.
- Adds asynchronous reset, stall (hold), bubble (NOP injection) and wrong-path exception squash.
- Carries srcA/srcB forward for forwarding logic.
- Adds saturating bubble/stall/squash performance counters and a sticky protocol-error flag.
- Sits between decode (D_*/d_*) and execute (E_*); controlled by the pipeline hazard unit.

Parameters:
DATA_W, 64, width of valC/valA/valB
REG_W, 4, register-ID width (dstE, dstM, srcA, srcB)
STAT_W, 3, status-code width
CNT_W, 32, performance-counter width
RESET_STAT, 1, E_stat value after reset and on bubble (AOK)

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
E_stall  in  1  hold current contents
E_bubble  in  1  load NOP bubble
D_stat  in  STAT_W  decode-stage status
D_icode, D_ifun  in  4 each  decode instruction code/function
D_valC  in  DATA_W  constant word
d_valA, d_valB  in  DATA_W  operand values (after forwarding)
d_dstE, d_dstM, d_srcA, d_srcB  in  REG_W  register IDs
M_icode  in  4  memory-stage icode (mispredict detect)
e_Cnd  in  1  execute condition result
E_stat  out  STAT_W  registered status
E_icode, E_ifun  out  4 each
E_valC, E_valA, E_valB  out  DATA_W
E_dstE, E_dstM, E_srcA, E_srcB  out  REG_W
E_valid  out  1  1 = real instruction held, 0 = reset/bubble content
bubble_cnt, stall_cnt, squash_cnt  out  CNT_W  saturating event counters
proto_err  out  1  sticky; set when E_stall and E_bubble are asserted together

Behaviour:
- Reset (async, any time, including mid-stall):
  - E_stat=RESET_STAT, E_icode=1 (NOP), E_ifun=0.
  - All val*=0; dstE/dstM/srcA/srcB=all-ones (RNONE).
  - E_valid=0, counters=0, proto_err=0.
  - First load occurs on the first rising edge after reset deasserts.
- Per-edge priority: bubble > stall > load.
- Bubble (E_bubble=1):
  - Register gets the reset image, except counters and proto_err.
  - bubble_cnt+1.
  - Differs from the old stage: val* and stat are also cleared, so nothing stale leaks.
- Stall (E_stall=1, E_bubble=0): all fields hold; E_valid holds; stall_cnt+1.
- Both asserted: bubble taken; stall_cnt unchanged; proto_err set until reset.
- Load (neither asserted):
  - All D_*/d_* fields captured; E_valid=1.
  - E_stat=D_stat, except when M_icode==7 (jXX) && e_Cnd==0 && D_stat!=AOK: then E_stat=AOK and squash_cnt+1. This suppresses wrong-path exceptions.
  - Squash applies only on a load cycle; it is not evaluated during stall or bubble.
- Latency: 1 cycle, input to output.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - Increments are independent, but at most one of bubble/stall fires per cycle.
- No combinational path from any input to any output.

Decomposition:
- y86_pkg holds:
  - icode constants: INOP=1, IJXX=7, plus the others.
  - Stat codes: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - RNONE=4'hF.
  - A packed struct e_bundle_t (stat, icode, ifun, valC, valA, valB, dst/src IDs) and its bubble constant.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated three times.

Test Plan:
- Reset asserted mid-cycle while holding D_icode=6, valA=5 → outputs go to the reset image at once, without waiting for a clock edge (icode=1, dstE=F, valA=0, E_valid=0).
- Load D_icode=6, ifun=0, valA=3, valB=4, dstE=2, stat=1; one edge → E_icode=6, E_valA=3, E_valB=4, E_dstE=2, E_valid=1.
- Stall 3 cycles while changing inputs → outputs unchanged, stall_cnt=3; release → new inputs captured on the next edge.
- Bubble plus stall in the same cycle → NOP image, bubble_cnt=1, stall_cnt=0, proto_err=1; proto_err stays 1 until reset.
- M_icode=7, e_Cnd=0, D_stat=4 on a load → E_stat=1, squash_cnt=1. Same with e_Cnd=1 → E_stat=4, squash_cnt unchanged.
- CNT_W=2, 5 consecutive bubbles → bubble_cnt saturates at 3.
